// File: rtl/sub_ctrl_pkg.sv
// rtl/sub_ctrl_pkg.sv - shared encodings for the nibble-serial subtract controller
package sub_ctrl_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] RUN_ENC  = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;
  localparam int NIB_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC,
    DONE = DONE_ENC
  } state_e;

endpackage

// File: rtl/sub4_slice.sv
// rtl/sub4_slice.sv - 4-bit ripple-borrow subtractor, d = a - b - bin
module sub4_slice
  import sub_ctrl_pkg::*;
(
  input  logic [NIB_BITS-1:0] a,
  input  logic [NIB_BITS-1:0] b,
  input  logic                bin,
  output logic [NIB_BITS-1:0] d,
  output logic                bout
);

  logic [NIB_BITS:0] brw;

  always_comb begin
    brw    = '0;
    d      = '0;
    brw[0] = bin;
    for (int i = 0; i < NIB_BITS; i++) begin
      d[i]     = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
    bout = brw[NIB_BITS];
  end

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// rtl/nibble_serial_sub_ctrl.sv - WIDTH-bit a - b - bin computed one nibble per clock
// through a single 4-bit slice, with valid/ready operand and result handshakes.
module nibble_serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_sub_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              brw_q, brw_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;

  logic [NIB_BITS-1:0] sl_a, sl_b, sl_d;
  logic                sl_bout;

  assign sl_a = a_q[idx_q*NIB_BITS +: NIB_BITS];
  assign sl_b = b_q[idx_q*NIB_BITS +: NIB_BITS];

  sub4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .bin  (brw_q),
    .d    (sl_d),
    .bout (sl_bout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[idx_q*NIB_BITS +: NIB_BITS] = sl_d;
        brw_d = sl_bout;
        // Flags see the fully assembled diff, including the nibble written this cycle.
        if (idx_q == IDX_LAST) begin
          bout_d  = sl_bout;
          zero_d  = (diff_d == '0);
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign zero        = zero_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// tb/tb_nibble_serial_sub_ctrl.sv - scoreboard bench for nibble_serial_sub_ctrl (WIDTH=16)
module tb_nibble_serial_sub_ctrl;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] diff;
  logic        bout, zero, ovf, busy;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_sub_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .bout        (bout),
    .zero        (zero),
    .ovf         (ovf),
    .busy        (busy)
  );

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    logic [16:0] full;
    exp_t e;
    full   = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    e.diff = full[15:0];
    e.bout = full[16];
    e.zero = (full[15:0] == 16'd0);
    e.ovf  = (ma[15] ^ mb[15]) & (ma[15] ^ full[15]);
    return e;
  endfunction

  task automatic compare_result(input string name);
    exp_t e;
    exp_t got;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: result with empty scoreboard, got diff=%h", name, diff);
    end else begin
      e   = sb.pop_front();
      got = '{diff: diff, bout: bout, zero: zero, ovf: ovf};
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got diff=%h bout=%b zero=%b ovf=%b expected diff=%h bout=%b zero=%b ovf=%b",
                 name, got.diff, got.bout, got.zero, got.ovf, e.diff, e.bout, e.zero, e.ovf);
      end
    end
  endtask

  // Launch one op from IDLE, wait for DONE measuring latency, compare, then hand off the result.
  task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    int n;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start_valid = 1'b1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: start_ready=%b expected 1", name, start_ready);
    end
    sb.push_back(model(ta, tb_, tbin));
    @(posedge clk);
    #1 start_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!res_valid && n < 20);
    checks++;
    if (res_valid !== 1'b1 || n != 4) begin
      failures++;
      $display("FAIL %s_latency: res_valid=%b after %0d edges expected 1 after 4", name, res_valid, n);
    end
    compare_result(name);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_handoff: res_valid=%b start_ready=%b expected 0 1", name, res_valid, start_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({res_valid, start_ready, busy, diff, bout, zero, ovf} !== {1'b0, 1'b1, 1'b0, 16'h0, 3'b000}) begin
      failures++;
      $display("FAIL reset: rv=%b sr=%b busy=%b diff=%h bout=%b zero=%b ovf=%b expected 0 1 0 0000 0 0 0",
               res_valid, start_ready, busy, diff, bout, zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op("basic", 16'h1234, 16'h0234, 1'b0);
    run_op("borrow_ripple", 16'h0000, 16'h0001, 1'b0);
    run_op("signed_ovf", 16'h8000, 16'h0001, 1'b0);
    run_op("zero_bin", 16'h0005, 16'h0004, 1'b1);
  endtask

  task automatic test_backpressure();
    exp_t held;
    int n;
    @(negedge clk);
    a = 16'hA5A5; b = 16'h5A5A; bin = 1'b0; start_valid = 1'b1;
    sb.push_back(model(16'hA5A5, 16'h5A5A, 1'b0));
    held = model(16'hA5A5, 16'h5A5A, 1'b0);
    @(posedge clk);
    #1 a = 16'h0F0F; b = 16'h0101; bin = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!res_valid && n < 20);
    checks++;
    if (res_valid !== 1'b1 || n != 4) begin
      failures++;
      $display("FAIL bp_latency: res_valid=%b after %0d edges expected 1 after 4", res_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || diff !== held.diff || bout !== held.bout ||
          zero !== held.zero || ovf !== held.ovf) begin
        failures++;
        $display("FAIL bp_hold[%0d]: rv=%b sr=%b diff=%h bout=%b zero=%b ovf=%b expected 1 0 %h %b %b %b",
                 i, res_valid, start_ready, diff, bout, zero, ovf, held.diff, held.bout, held.zero, held.ovf);
      end
    end
    compare_result("bp_result");
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handoff: res_valid=%b start_ready=%b expected 0 1", res_valid, start_ready);
    end
    // start_valid has stayed high with new operands; the next edge accepts them.
    sb.push_back(model(16'h0F0F, 16'h0101, 1'b1));
    @(posedge clk);
    #1 start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_accept: busy=%b expected 1", busy);
    end
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!res_valid && n < 20);
    compare_result("bp_next_result");
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    run_op("pre_reset", 16'h0000, 16'h8000, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h0001; bin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, start_ready, busy, diff, bout, zero, ovf} !== {1'b0, 1'b1, 1'b0, 16'h0, 3'b000}) begin
      failures++;
      $display("FAIL mid_reset: rv=%b sr=%b busy=%b diff=%h bout=%b zero=%b ovf=%b expected 0 1 0 0000 0 0 0",
               res_valid, start_ready, busy, diff, bout, zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 16'h00FF, 16'h000F, 1'b0);
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int got = 0;
    int cyc = 0;
    int last_cyc = -1;
    logic [15:0] ra, rb;
    logic rbin;
    res_ready = 1'b1;
    start_valid = 1'b1;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        compare_result($sformatf("b2b_%0d", got));
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 6) begin
            failures++;
            $display("FAIL b2b_spacing_%0d: got %0d cycles expected 6", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      if (start_ready && issued < 8) begin
        ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
        a = ra; b = rb; bin = rbin;
        sb.push_back(model(ra, rb, rbin));
        issued++;
      end else if (start_ready) begin
        start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (got != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d results expected 8", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
